// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded control and operands in from ID, registered
// control/data out to EX, plus the load-use stall indications.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [1:0]        ID_RegDst;
    logic              ID_ALUSrcB;
    logic [3:0]        ID_ALUOp;
    logic [1:0]        ID_BranchType;
    logic              ID_MemWre;
    logic              ID_MemRead;
    logic              ID_RegWre;
    logic [1:0]        ID_DBDataSrc;
    logic              ID_EX_Flush;
    logic [DATA_W-1:0] ID_PC4, ID_ReadData1, ID_ReadData2, ID_Imm32;
    logic [REG_AW-1:0] ID_rs, ID_rt, ID_rd;

    logic [1:0]        EX_RegDst;
    logic              EX_ALUSrcB;
    logic [3:0]        EX_ALUOp;
    logic [1:0]        EX_BranchType;
    logic              EX_MemWre;
    logic              EX_MemRead;
    logic              EX_RegWre;
    logic [1:0]        EX_DBDataSrc;
    logic [DATA_W-1:0] EX_PC4, EX_ReadData1, EX_ReadData2, EX_Imm32;
    logic [REG_AW-1:0] EX_rs, EX_rt, EX_rd;
    logic              EX_Valid;

    logic              ControlSrc;
    logic              PCStall;
    logic              IF_ID_Stall;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output ID_RegDst, ID_ALUSrcB, ID_ALUOp, ID_BranchType, ID_MemWre,
               ID_MemRead, ID_RegWre, ID_DBDataSrc, ID_EX_Flush,
               ID_PC4, ID_ReadData1, ID_ReadData2, ID_Imm32, ID_rs, ID_rt, ID_rd,
        input  EX_RegDst, EX_ALUSrcB, EX_ALUOp, EX_BranchType, EX_MemWre,
               EX_MemRead, EX_RegWre, EX_DBDataSrc,
               EX_PC4, EX_ReadData1, EX_ReadData2, EX_Imm32, EX_rs, EX_rt, EX_rd,
               EX_Valid, ControlSrc, PCStall, IF_ID_Stall, StallCount
    );

    modport slave (
        input  ID_RegDst, ID_ALUSrcB, ID_ALUOp, ID_BranchType, ID_MemWre,
               ID_MemRead, ID_RegWre, ID_DBDataSrc, ID_EX_Flush,
               ID_PC4, ID_ReadData1, ID_ReadData2, ID_Imm32, ID_rs, ID_rt, ID_rd,
        output EX_RegDst, EX_ALUSrcB, EX_ALUOp, EX_BranchType, EX_MemWre,
               EX_MemRead, EX_RegWre, EX_DBDataSrc,
               EX_PC4, EX_ReadData1, EX_ReadData2, EX_Imm32, EX_rs, EX_rt, EX_rd,
               EX_Valid, ControlSrc, PCStall, IF_ID_Stall, StallCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, load-use detection, one-cycle bubble
// insertion and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic          CLK,
    input logic          Reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [1:0] reg_dst;
        logic       alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] branch_type;
        logic       mem_wre;
        logic       mem_read;
        logic       reg_wre;
        logic [1:0] db_data_src;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } data_t;

    ctrl_t            id_ctrl, ctrl_q, ctrl_d;
    data_t            id_data, data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             stall;

    assign id_ctrl = {bus.ID_RegDst, bus.ID_ALUSrcB, bus.ID_ALUOp, bus.ID_BranchType,
                      bus.ID_MemWre, bus.ID_MemRead, bus.ID_RegWre, bus.ID_DBDataSrc};
    assign id_data = {bus.ID_PC4, bus.ID_ReadData1, bus.ID_ReadData2, bus.ID_Imm32,
                      bus.ID_rs, bus.ID_rt, bus.ID_rd};

    // Load in EX writing a register that the instruction in ID reads; $0 never counts.
    // The rt compare is conservative: a store's data register also stalls.
    assign load_use = ctrl_q.mem_read & ctrl_q.reg_wre & (data_q.rt != '0) &
                      ((data_q.rt == bus.ID_rs) | (data_q.rt == bus.ID_rt));
    // A flush redirects fetch anyway, so it suppresses the stall.
    assign stall    = load_use & ~bus.ID_EX_Flush;

    // Next-state selection: flush beats bubble beats normal issue.
    always_comb begin
        ctrl_d  = id_ctrl;
        data_d  = id_data;
        valid_d = 1'b1;
        cnt_d   = cnt_q;
        if (bus.ID_EX_Flush) begin
            ctrl_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            // Data still loads; with the controls cleared it is never used.
            ctrl_d  = '0;
            valid_d = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pipeline register and counter state.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.EX_RegDst     = ctrl_q.reg_dst;
    assign bus.EX_ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.EX_ALUOp      = ctrl_q.alu_op;
    assign bus.EX_BranchType = ctrl_q.branch_type;
    assign bus.EX_MemWre     = ctrl_q.mem_wre;
    assign bus.EX_MemRead    = ctrl_q.mem_read;
    assign bus.EX_RegWre     = ctrl_q.reg_wre;
    assign bus.EX_DBDataSrc  = ctrl_q.db_data_src;
    assign bus.EX_PC4        = data_q.pc4;
    assign bus.EX_ReadData1  = data_q.rd1;
    assign bus.EX_ReadData2  = data_q.rd2;
    assign bus.EX_Imm32      = data_q.imm;
    assign bus.EX_rs         = data_q.rs;
    assign bus.EX_rt         = data_q.rt;
    assign bus.EX_rd         = data_q.rd;
    assign bus.EX_Valid      = valid_q;
    assign bus.StallCount    = cnt_q;
    assign bus.ControlSrc    = stall;
    assign bus.PCStall       = stall;
    assign bus.IF_ID_Stall   = stall;
endmodule
